sum_accumulator: RTL and testbench
==================================

Name: sum_accumulator

Overview:
Downstream stage of the 4-bit ripple-carry adder. It consumes the adder's {Cout, S} result as a (DATA_W+1)-bit unsigned value, one value per valid/ready transfer. It accumulates a frame of up to COUNT values and presents the frame total with a sticky overflow flag. The result is held on a valid/ready output until the consumer takes it.

Parameters:
DATA_W, 4, width of adder sum S; each input value is DATA_W+1 bits including the carry.
COUNT, 4, maximum values per frame; must be at least 1.
ACC_W, 8, accumulator and result width; must be at least DATA_W+1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_sum  input  DATA_W  adder sum S.
in_carry  input  1  adder carry Cout; value = {in_carry, in_sum}.
in_valid  input  1  input value present.
in_last  input  1  qualified by an input accept; closes the frame early.
in_ready  output  1  block can accept a value.
flush  input  1  abort the current frame.
out_acc  output  ACC_W  frame total, modulo 2^ACC_W.
out_count  output  clog2(COUNT+1)  number of values in the frame.
out_ovf  output  1  frame total exceeded 2^ACC_W-1.
out_valid  output  1  result present.
out_ready  input  1  consumer takes the result.

Behaviour:
- Accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Reset state: IDLE, with acc=0, cnt=0, ovf=0. Outputs after reset: out_valid=0, in_ready=1, out_acc=0, out_count=0, out_ovf=0.
- Each input value is zero-extended to ACC_W+1 bits. The addition is done at ACC_W+1 bits. Bit ACC_W of the result sets ovf, which stays set for the rest of the frame; acc keeps the low ACC_W bits.
- States are IDLE, ACCUM and DONE. in_ready=1 in IDLE and ACCUM, and 0 in DONE. out_valid=1 only in DONE.
- IDLE:
  - Accept: acc=value, cnt=1, ovf=0.
  - Go to DONE if in_last or COUNT==1; otherwise go to ACCUM.
- ACCUM:
  - Accept: acc=acc+value, cnt=cnt+1.
  - Go to DONE if in_last or the new cnt==COUNT; otherwise stay in ACCUM.
  - No accept: hold all state.
- DONE:
  - out_acc, out_count and out_ovf are registered and stable for as long as out_valid=1.
  - Output transfer: go to IDLE; acc, cnt and ovf clear.
  - The next input is accepted no earlier than the cycle after the transfer.
- Latency: out_valid rises on the clock edge that takes the closing accept, so the result is visible in the following cycle.
- in_last is ignored when there is no accept.
- flush:
  - In IDLE or ACCUM: go to IDLE and clear acc, cnt and ovf. Any input presented in the same cycle is dropped, not accepted.
  - In DONE: ignored. A completed result is never discarded.
- rst has priority over flush. rst asserted in any state, including mid-frame or while out_valid=1, returns to the reset state on the next edge.
- out_* port values outside DONE: out_acc and out_count show the running acc and cnt; out_ovf shows the running ovf. The consumer must qualify them with out_valid.

Decomposition:
- Shared package sum_acc_pkg holds:
  - the state enum (IDLE, ACCUM, DONE);
  - the default widths DATA_W=4 and ACC_W=8;
  - the function for the out_count width, clog2(COUNT+1).
- No sub-module is needed. The adder itself stays outside this block and its S and Cout connect directly to in_sum and in_carry.

Test Plan:
1. Overflow-free full frame: after rst, apply four accepts of {1,1111} (value 31) with out_ready=1. Require out_valid=1 in the cycle after the 4th accept, with out_acc=124, out_count=4, out_ovf=0. Require IDLE in the following cycle.
2. Wrap and sticky overflow (ACC_W=6, COUNT=4): apply 31, 31, 31, then 0. Require out_acc=29, out_ovf=1 and out_count=4; the flag stays set after the 0.
3. Early close: apply 5, then 7 with in_last=1. Require out_acc=12, out_count=2 and out_valid in the next cycle.
4. Backpressure: hold out_ready=0 for 5 cycles with result 124 pending and in_valid=1. Require out_acc stable at 124, in_ready=0 and no accept. When out_ready=1, require exactly one transfer, then in_ready=1.
5. Flush mid-frame: apply 9, 9, then flush=1 with in_valid=1, then 3, 3, 3, 3. Require the flush-cycle input to be dropped and the result to be out_acc=12, out_count=4. Also assert flush while in DONE: the result must be unchanged.
6. Reset priority: after two accepts (acc=10), assert rst and flush together. Require all outputs at their reset values and in_ready=1 on the next cycle, and the next frame to start from acc=0.

Source files
------------

// File: rtl/sum_acc_pkg.sv
// rtl/sum_acc_pkg.sv - shared state encoding, default widths and count-width helper for sum_accumulator
package sum_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ACC_W  = 8;

  // Width needed to hold a frame count in the range 0..count.
  function automatic int cnt_width(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - frames {carry, sum} adder results into a running total with sticky overflow
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COUNT  = 4,
  parameter int ACC_W  = DEF_ACC_W,
  localparam int CNT_W = cnt_width(COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_carry,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              flush,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PAD_W = ACC_W - DATA_W;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               out_valid_q;
  logic               in_ready_q;

  logic [ACC_W:0]     value_ext;
  logic [ACC_W:0]     sum_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               accept;
  logic               close_d;

  always_comb begin
    value_ext = {{PAD_W{1'b0}}, in_carry, in_sum};
    sum_d     = {1'b0, acc_q} + value_ext;
    cnt_d     = cnt_q + 1'b1;
    // A flush in the same cycle drops the presented input.
    accept    = in_valid && in_ready_q && !flush;
    close_d   = in_last || (state_q == ST_IDLE ? (COUNT == 1) : (cnt_d == CNT_W'(COUNT)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (flush) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end else if (accept) begin
            if (state_q == ST_IDLE) begin
              acc_q <= value_ext[ACC_W-1:0];
              cnt_q <= CNT_W'(1);
              ovf_q <= 1'b0;
            end else begin
              acc_q <= sum_d[ACC_W-1:0];
              cnt_q <= cnt_d;
              ovf_q <= ovf_q | sum_d[ACC_W];
            end
            if (close_d) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              state_q <= ST_ACCUM;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          acc_q       <= '0;
          cnt_q       <= '0;
          ovf_q       <= 1'b0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - directed vector bench for sum_accumulator (default widths plus a 6-bit accumulator)
module tb_sum_accumulator;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DATA_W=4, COUNT=4, ACC_W=8
  logic       rst, in_carry, in_valid, in_last, in_ready, flush, out_ovf, out_valid, out_ready;
  logic [3:0] in_sum;
  logic [7:0] out_acc;
  logic [2:0] out_count;

  // Instance B: DATA_W=4, COUNT=4, ACC_W=6
  logic       b_rst, b_in_carry, b_in_valid, b_in_last, b_in_ready, b_flush, b_out_ovf, b_out_valid, b_out_ready;
  logic [3:0] b_in_sum;
  logic [5:0] b_out_acc;
  logic [2:0] b_out_count;

  sum_accumulator #(.DATA_W(4), .COUNT(4), .ACC_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_sum(in_sum), .in_carry(in_carry), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .flush(flush), .out_acc(out_acc),
    .out_count(out_count), .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  sum_accumulator #(.DATA_W(4), .COUNT(4), .ACC_W(6)) dut_b (
    .clk(clk), .rst(b_rst), .in_sum(b_in_sum), .in_carry(b_in_carry), .in_valid(b_in_valid),
    .in_last(b_in_last), .in_ready(b_in_ready), .flush(b_flush), .out_acc(b_out_acc),
    .out_count(b_out_count), .out_ovf(b_out_ovf), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [4:0] value;
    logic       last;
    logic       flush;
    logic       ordy;
    logic       e_valid;
    logic       e_ready;
    int         e_acc;
    int         e_cnt;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int idx, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, got, exp);
    end
  endtask

  // Expected values are the outputs after the clock edge that consumes the inputs.
  task automatic add(input logic r, input logic v, input int val, input logic l, input logic f,
                     input logic o, input logic ev, input logic er, input int ea, input int ec,
                     input logic eo);
    vec_t t;
    t.rst = r; t.valid = v; t.value = 5'(val); t.last = l; t.flush = f; t.ordy = o;
    t.e_valid = ev; t.e_ready = er; t.e_acc = ea; t.e_cnt = ec; t.e_ovf = eo;
    vecs.push_back(t);
  endtask

  task automatic b_step(input logic v, input int val, input logic l, input int idx,
                        input logic ev, input int ea, input int ec, input logic eo);
    logic [4:0] w;
    w = 5'(val);
    b_in_valid = v; b_in_sum = w[3:0]; b_in_carry = w[4]; b_in_last = l;
    @(posedge clk); #1;
    check("b_valid", idx, int'(b_out_valid), int'(ev));
    check("b_acc",   idx, int'(b_out_acc),   ea);
    check("b_count", idx, int'(b_out_count), ec);
    check("b_ovf",   idx, int'(b_out_ovf),   int'(eo));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = 1'b0; in_last = 1'b0; flush = 1'b0; out_ready = 1'b0;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_sum = '0; b_in_carry = 1'b0; b_in_last = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;

    //  rst v  val l  f  ordy | valid ready acc cnt ovf
    // Full frame of 31s, no overflow at 8 bits
    add(0, 1, 31, 0, 0, 1,   0, 1,  31, 1, 0);
    add(0, 1, 31, 0, 0, 1,   0, 1,  62, 2, 0);
    add(0, 1, 31, 0, 0, 1,   0, 1,  93, 3, 0);
    add(0, 1, 31, 0, 0, 1,   1, 0, 124, 4, 0);
    add(0, 0,  0, 0, 0, 1,   0, 1,   0, 0, 0);
    // Early close; in_last without accept is ignored
    add(0, 1,  5, 0, 0, 1,   0, 1,   5, 1, 0);
    add(0, 0,  0, 1, 0, 1,   0, 1,   5, 1, 0);
    add(0, 1,  7, 1, 0, 1,   1, 0,  12, 2, 0);
    add(0, 0,  0, 0, 0, 1,   0, 1,   0, 0, 0);
    // Backpressure with in_valid held high
    add(0, 1, 31, 0, 0, 0,   0, 1,  31, 1, 0);
    add(0, 1, 31, 0, 0, 0,   0, 1,  62, 2, 0);
    add(0, 1, 31, 0, 0, 0,   0, 1,  93, 3, 0);
    add(0, 1, 31, 0, 0, 0,   1, 0, 124, 4, 0);
    for (int k = 0; k < 5; k++) add(0, 1, 5, 0, 0, 0,   1, 0, 124, 4, 0);
    add(0, 1,  5, 0, 0, 1,   0, 1,   0, 0, 0);
    add(0, 0,  0, 0, 0, 1,   0, 1,   0, 0, 0);
    // Flush mid-frame drops the same-cycle input; flush in DONE is ignored
    add(0, 1,  9, 0, 0, 1,   0, 1,   9, 1, 0);
    add(0, 1,  9, 0, 0, 1,   0, 1,  18, 2, 0);
    add(0, 1,  9, 0, 1, 1,   0, 1,   0, 0, 0);
    add(0, 1,  3, 0, 0, 0,   0, 1,   3, 1, 0);
    add(0, 1,  3, 0, 0, 0,   0, 1,   6, 2, 0);
    add(0, 1,  3, 0, 0, 0,   0, 1,   9, 3, 0);
    add(0, 1,  3, 0, 0, 0,   1, 0,  12, 4, 0);
    add(0, 0,  0, 0, 1, 0,   1, 0,  12, 4, 0);
    add(0, 0,  0, 0, 0, 1,   0, 1,   0, 0, 0);
    // Reset wins over flush mid-frame, next frame starts from zero
    add(0, 1,  5, 0, 0, 0,   0, 1,   5, 1, 0);
    add(0, 1,  5, 0, 0, 0,   0, 1,  10, 2, 0);
    add(1, 1,  5, 0, 1, 0,   0, 1,   0, 0, 0);
    add(0, 1,  7, 0, 0, 0,   0, 1,   7, 1, 0);
    add(0, 1,  8, 1, 0, 0,   1, 0,  15, 2, 0);
    // Reset while a result is pending
    add(1, 0,  0, 0, 0, 0,   0, 1,   0, 0, 0);

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_valid", 0, int'(out_valid), 0);
    check("rst_ready", 0, int'(in_ready),  1);
    check("rst_acc",   0, int'(out_acc),   0);
    check("rst_count", 0, int'(out_count), 0);
    check("rst_ovf",   0, int'(out_ovf),   0);
    rst = 1'b0; b_rst = 1'b0;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; in_valid = vecs[i].valid; in_sum = vecs[i].value[3:0];
      in_carry = vecs[i].value[4]; in_last = vecs[i].last; flush = vecs[i].flush;
      out_ready = vecs[i].ordy;
      @(posedge clk); #1;
      check("valid", i, int'(out_valid), int'(vecs[i].e_valid));
      check("ready", i, int'(in_ready),  int'(vecs[i].e_ready));
      check("acc",   i, int'(out_acc),   vecs[i].e_acc);
      check("count", i, int'(out_count), vecs[i].e_cnt);
      check("ovf",   i, int'(out_ovf),   int'(vecs[i].e_ovf));
    end
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;

    // 6-bit accumulator: 31+31 = 62, +31 = 93 wraps to 29 with ovf, +0 keeps ovf
    b_step(1, 31, 0, 0, 0, 31, 1, 0);
    b_step(1, 31, 0, 1, 0, 62, 2, 0);
    b_step(1, 31, 0, 2, 0, 29, 3, 1);
    b_step(1,  0, 0, 3, 1, 29, 4, 1);
    b_step(0,  0, 0, 4, 0,  0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
